// File: rtl/pcm_stream_mixer.sv
// -----------------------------------------------------------------------------
// pcm_stream_mixer
//
// Sample-rate mixer between several 8-bit unsigned PCM sources and one PWM
// audio stage. Each channel keeps the newest sample it accepted. Once every DIV
// clock cycles the enabled channels are summed, one channel per cycle, each
// with its own arithmetic-shift attenuation. The mixed sample is then offered
// downstream on a valid/ready handshake and held between updates.
//
// Optional feature macro: PCM_MIX_SAT_EN
//   defined   : the sum is saturated to [-128, 127] (full loudness, hard clip)
//   undefined : the sum is divided by NCH with an arithmetic shift (never clips)
//
// Parameters
//   NCH  channel count, power of two, 2..8
//   DIV  sample period in clk cycles, >= NCH+3
//
// Ports
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   ch_en    in   [NCH]    per-channel mix enable
//   gain     in   [2*NCH]  per-channel right shift 0..3, channel i in [2i+1:2i]
//   pcm_in   in   [8*NCH]  channel i sample in [8i+7:8i], 0x80 = silence
//   pcm_vld  in   [NCH]    per-channel sample valid
//   pcm_rdy  out  [NCH]    per-channel ready (no unconsumed sample held)
//   mix_out  out  [8]      mixed sample, 0x80 = silence
//   mix_vld  out           mixed sample valid
//   mix_rdy  in            downstream ready
//   overrun  out           sticky: a sample tick arrived while busy
// -----------------------------------------------------------------------------
module pcm_stream_mixer #(
   parameter int NCH = 4,
   parameter int DIV = 512
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NCH-1:0]     ch_en,
   input  logic [2*NCH-1:0]   gain,
   input  logic [8*NCH-1:0]   pcm_in,
   input  logic [NCH-1:0]     pcm_vld,
   output logic [NCH-1:0]     pcm_rdy,
   output logic [7:0]         mix_out,
   output logic               mix_vld,
   input  logic               mix_rdy,
   output logic               overrun
);

   localparam int LG = $clog2(NCH);
   localparam int AW = 9 + LG;
   localparam int TW = $clog2(DIV);
   localparam logic [LG-1:0] LAST_IDX = LG'(NCH - 1);
   localparam logic [TW-1:0] TICK_CNT = TW'(DIV - 1);

`ifdef PCM_MIX_SAT_EN
   localparam logic signed [AW-1:0] SAT_HI = AW'(127);
   localparam logic signed [AW-1:0] SAT_LO = AW'(-128);
`endif

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_OUT   = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [TW-1:0]          tcnt_q, tcnt_d;
   logic [LG-1:0]          idx_q, idx_d;
   logic signed [AW-1:0]   acc_q, acc_d;
   logic [7:0]             hold_q [NCH];
   logic [7:0]             hold_d [NCH];
   logic [NCH-1:0]         fresh_q, fresh_d;
   logic [7:0]             mix_out_q, mix_out_d;
   logic                   mix_vld_q, mix_vld_d;
   logic                   overrun_q, overrun_d;

   logic                   tick_s;
   logic                   last_s;
   logic signed [8:0]      smp_s;
   logic signed [8:0]      contrib_s;
   logic signed [AW-1:0]   acc_nxt_s;

   logic [1:0]             gain_a [NCH];
   logic [7:0]             pcm_a  [NCH];

   // Unpack the flat per-channel buses into arrays indexed by channel number.
   for (genvar g = 0; g < NCH; g++) begin : g_unpack
      assign gain_a[g] = gain[2*g +: 2];
      assign pcm_a[g]  = pcm_in[8*g +: 8];
   end

   // Turn the signed sum into the unsigned offset-binary output sample.
   // A signed 8-bit value plus 128 is the same bits with the MSB inverted.
   function automatic logic [7:0] to_offset(input logic signed [AW-1:0] a);
      logic signed [7:0] c;
`ifdef PCM_MIX_SAT_EN
      if (a > SAT_HI) begin
         c = 8'sh7F;
      end else if (a < SAT_LO) begin
         c = 8'sh80;
      end else begin
         c = 8'(a);
      end
`else
      // The sum of NCH values in [-128,127] shifted by log2(NCH) always fits.
      c = 8'(a >>> LG);
`endif
      return {~c[7], c[6:0]};
   endfunction

   assign tick_s = (tcnt_q == TICK_CNT);
   assign last_s = (idx_q == LAST_IDX);

   // Contribution of the channel currently being accumulated.
   always_comb begin
      smp_s     = $signed({1'b0, hold_q[idx_q]}) - 9'sd128;
      contrib_s = smp_s >>> gain_a[idx_q];
      if (ch_en[idx_q]) begin
         acc_nxt_s = acc_q + $signed({{LG{contrib_s[8]}}, contrib_s});
      end else begin
         acc_nxt_s = acc_q;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (tick_s) begin
               state_d = ST_ACCUM;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACCUM: begin
            if (last_s) begin
               state_d = ST_OUT;
            end else begin
               state_d = ST_ACCUM;
            end
         end
         ST_OUT: begin
            if (mix_rdy) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_OUT;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM outputs and datapath next-state values.
   always_comb begin
      tcnt_d    = tick_s ? {TW{1'b0}} : tcnt_q + TW'(1);
      idx_d     = idx_q;
      acc_d     = acc_q;
      hold_d    = hold_q;
      fresh_d   = fresh_q;
      mix_out_d = mix_out_q;
      mix_vld_d = mix_vld_q;
      overrun_d = overrun_q;

      case (state_q)
         ST_IDLE: begin
            if (tick_s) begin
               idx_d = {LG{1'b0}};
               acc_d = {AW{1'b0}};
            end else begin
               idx_d = idx_q;
            end
         end
         ST_ACCUM: begin
            acc_d          = acc_nxt_s;
            fresh_d[idx_q] = 1'b0;
            idx_d          = idx_q + LG'(1);
            if (last_s) begin
               mix_out_d = to_offset(acc_nxt_s);
               mix_vld_d = 1'b1;
            end else begin
               mix_vld_d = mix_vld_q;
            end
         end
         ST_OUT: begin
            if (mix_rdy) begin
               mix_vld_d = 1'b0;
            end else begin
               mix_vld_d = 1'b1;
            end
         end
         default: begin
            mix_vld_d = 1'b0;
         end
      endcase

      // A tick that finds the mixer busy is lost for good.
      if (tick_s && (state_q != ST_IDLE)) begin
         overrun_d = 1'b1;
      end else begin
         overrun_d = overrun_q;
      end

      // Capture comes after the ACCUM clear so a same-cycle capture leaves
      // fresh set; the ACCUM read above already used the old hold value.
      for (int i = 0; i < NCH; i++) begin
         if (pcm_vld[i] && !fresh_q[i]) begin
            hold_d[i]  = pcm_a[i];
            fresh_d[i] = 1'b1;
         end else begin
            hold_d[i]  = hold_d[i];
         end
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tcnt_q    <= {TW{1'b0}};
         idx_q     <= {LG{1'b0}};
         acc_q     <= {AW{1'b0}};
         fresh_q   <= {NCH{1'b0}};
         mix_out_q <= 8'h80;
         mix_vld_q <= 1'b0;
         overrun_q <= 1'b0;
         for (int i = 0; i < NCH; i++) begin
            hold_q[i] <= 8'h80;
         end
      end else begin
         tcnt_q    <= tcnt_d;
         idx_q     <= idx_d;
         acc_q     <= acc_d;
         fresh_q   <= fresh_d;
         mix_out_q <= mix_out_d;
         mix_vld_q <= mix_vld_d;
         overrun_q <= overrun_d;
         for (int i = 0; i < NCH; i++) begin
            hold_q[i] <= hold_d[i];
         end
      end
   end

   assign pcm_rdy = ~fresh_q;
   assign mix_out = mix_out_q;
   assign mix_vld = mix_vld_q;
   assign overrun = overrun_q;

endmodule

// File: tb/tb_pcm_stream_mixer.sv
// -----------------------------------------------------------------------------
// Self-checking bench for pcm_stream_mixer with NCH=4, DIV=16.
// Expected mix values come from an integer model of the mixing rule.
// -----------------------------------------------------------------------------
module tb_pcm_stream_mixer;

   localparam int NCH = 4;
   localparam int DIV = 16;

`ifdef PCM_MIX_SAT_EN
   localparam logic [7:0] EXP_C0  = 8'hFF;
   localparam logic [7:0] EXP_G1  = 8'hBF;
   localparam logic [7:0] EXP_NEG = 8'h00;
`else
   localparam logic [7:0] EXP_C0  = 8'hC0;
   localparam logic [7:0] EXP_G1  = 8'h8F;
   localparam logic [7:0] EXP_NEG = 8'h40;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  ch_en = 4'h0;
   logic [7:0]  gain = 8'h00;
   logic [31:0] pcm_in = 32'h0;
   logic [3:0]  pcm_vld = 4'h0;
   logic [3:0]  pcm_rdy;
   logic [7:0]  mix_out;
   logic        mix_vld;
   logic        mix_rdy = 1'b1;
   logic        overrun;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc;

   pcm_stream_mixer #(.NCH(NCH), .DIV(DIV)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ch_en   (ch_en),
      .gain    (gain),
      .pcm_in  (pcm_in),
      .pcm_vld (pcm_vld),
      .pcm_rdy (pcm_rdy),
      .mix_out (mix_out),
      .mix_vld (mix_vld),
      .mix_rdy (mix_rdy),
      .overrun (overrun)
   );

   always #5 clk = ~clk;

   // Cycle index since reset release; at a falling edge it names the current cycle.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   function automatic int shr_floor(input int v, input int s);
      int d;
      d = 1 << s;
      if (v >= 0) return v / d;
      return -((-v + d - 1) / d);
   endfunction

   function automatic logic [7:0] model_mix(input logic [31:0] smp, input logic [3:0] en,
                                            input logic [7:0] g);
      int acc;
      acc = 0;
      for (int i = 0; i < NCH; i++) begin
         if (en[i]) acc += shr_floor(int'(smp[8*i +: 8]) - 128, int'(g[2*i +: 2]));
      end
`ifdef PCM_MIX_SAT_EN
      if (acc > 127)  acc = 127;
      if (acc < -128) acc = -128;
`else
      acc = shr_floor(acc, 2);
`endif
      return 8'(acc + 128);
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst_n   = 1'b0;
      pcm_vld = 4'h0;
      pcm_in  = 32'h0;
      mix_rdy = 1'b1;
      ch_en   = 4'hF;
      gain    = 8'h00;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic goto_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (mix_out !== 8'h80) begin n_bad++; $display("FAIL reset_mix_out: got %h want 80", mix_out); end
      n_cmp++; if (mix_vld !== 1'b0) begin n_bad++; $display("FAIL reset_mix_vld: got %b want 0", mix_vld); end
      n_cmp++; if (pcm_rdy !== 4'b1111) begin n_bad++; $display("FAIL reset_pcm_rdy: got %b want 1111", pcm_rdy); end
      n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
      while (mix_vld !== 1'b1 && cyc < 40) @(negedge clk);
      n_cmp++; if (cyc !== 20) begin n_bad++; $display("FAIL first_vld_cycle: got %0d want 20", cyc); end
      n_cmp++; if (mix_out !== 8'h80) begin n_bad++; $display("FAIL silent_mix: got %h want 80", mix_out); end
      @(negedge clk);
      n_cmp++; if (mix_vld !== 1'b0 || mix_out !== 8'h80)
         begin n_bad++; $display("FAIL after_handshake: got vld=%b out=%h want vld=0 out=80", mix_vld, mix_out); end
   endtask

   task automatic test_all_c0();
      logic [3:0] exp_rdy;
      do_reset();
      pcm_in  = {4{8'hC0}};
      pcm_vld = 4'hF;
      @(negedge clk);
      pcm_vld = 4'h0;
      n_cmp++; if (pcm_rdy !== 4'b0000) begin n_bad++; $display("FAIL c0_rdy_low: got %b want 0000", pcm_rdy); end
      for (int c = 16; c <= 20; c++) begin
         goto_cyc(c);
         for (int i = 0; i < NCH; i++) exp_rdy[i] = (c >= 17 + i);
         n_cmp++; if (pcm_rdy !== exp_rdy)
            begin n_bad++; $display("FAIL c0_rdy_cyc%0d: got %b want %b", c, pcm_rdy, exp_rdy); end
      end
      n_cmp++; if (mix_vld !== 1'b1) begin n_bad++; $display("FAIL c0_vld: got %b want 1", mix_vld); end
      n_cmp++; if (mix_out !== model_mix({4{8'hC0}}, 4'hF, 8'h00))
         begin n_bad++; $display("FAIL c0_model: got %h want %h", mix_out, model_mix({4{8'hC0}}, 4'hF, 8'h00)); end
      n_cmp++; if (mix_out !== EXP_C0) begin n_bad++; $display("FAIL c0_const: got %h want %h", mix_out, EXP_C0); end
   endtask

   task automatic test_gain();
      logic [31:0] s;
      logic [7:0]  g;
      do_reset();
      s = {$urandom_range(255, 0) & 24'hFFFFFF, 8'hFF};
      s[31:8] = 24'($urandom);
      g = {6'($urandom), 2'b01};
      ch_en   = 4'b0001;
      gain    = g;
      pcm_in  = s;
      pcm_vld = 4'hF;
      @(negedge clk);
      pcm_vld = 4'h0;
      goto_cyc(20);
      n_cmp++; if (mix_vld !== 1'b1 || mix_out !== model_mix(s, 4'b0001, g))
         begin n_bad++; $display("FAIL gain_model: got vld=%b out=%h want %h", mix_vld, mix_out, model_mix(s, 4'b0001, g)); end
      n_cmp++; if (mix_out !== EXP_G1) begin n_bad++; $display("FAIL gain_const: got %h want %h", mix_out, EXP_G1); end
   endtask

   task automatic test_negative();
      logic [31:0] s;
      logic [7:0]  g;
      do_reset();
      s = {16'($urandom), 16'h0000};
      g = {4'($urandom), 4'b0000};
      ch_en   = 4'b0011;
      gain    = g;
      pcm_in  = s;
      pcm_vld = 4'hF;
      @(negedge clk);
      pcm_vld = 4'h0;
      goto_cyc(20);
      n_cmp++; if (mix_vld !== 1'b1 || mix_out !== model_mix(s, 4'b0011, g))
         begin n_bad++; $display("FAIL neg_model: got vld=%b out=%h want %h", mix_vld, mix_out, model_mix(s, 4'b0011, g)); end
      n_cmp++; if (mix_out !== EXP_NEG) begin n_bad++; $display("FAIL neg_const: got %h want %h", mix_out, EXP_NEG); end
   endtask

   task automatic test_stall_overrun();
      logic [31:0] s;
      logic [7:0]  held;
      int          bad_cyc;
      do_reset();
      s = $urandom;
      pcm_in  = s;
      pcm_vld = 4'hF;
      mix_rdy = 1'b0;
      @(negedge clk);
      pcm_vld = 4'h0;
      goto_cyc(20);
      held = mix_out;
      n_cmp++; if (mix_vld !== 1'b1 || held !== model_mix(s, 4'hF, 8'h00))
         begin n_bad++; $display("FAIL stall_first: got vld=%b out=%h want %h", mix_vld, held, model_mix(s, 4'hF, 8'h00)); end
      goto_cyc(30);
      n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL overrun_early: got %b want 0", overrun); end
      bad_cyc = -1;
      for (int c = 21; c <= 52; c++) begin
         goto_cyc(c);
         if ((mix_vld !== 1'b1 || mix_out !== held) && bad_cyc < 0) bad_cyc = c;
      end
      n_cmp++; if (bad_cyc >= 0)
         begin n_bad++; $display("FAIL stall_hold: cycle %0d vld/out changed, want vld=1 out=%h", bad_cyc, held); end
      n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL overrun_set: got %b want 1", overrun); end
      mix_rdy = 1'b1;
      @(negedge clk);
      mix_rdy = 1'b0;
      n_cmp++; if (mix_vld !== 1'b0 || overrun !== 1'b1 || mix_out !== held)
         begin n_bad++; $display("FAIL stall_release: got vld=%b ovr=%b out=%h want 0 1 %h", mix_vld, overrun, mix_out, held); end
      mix_rdy = 1'b1;
   endtask

   task automatic test_capture_collision();
      logic [31:0] s;
      logic [31:0] s_old;
      logic [31:0] s_new;
      do_reset();
      s = $urandom;
      pcm_in  = s;
      pcm_vld = 4'b1011;
      @(negedge clk);
      pcm_vld = 4'h0;
      s_old = s;
      s_old[23:16] = 8'h80;
      s_new = s;
      s_new[23:16] = 8'h90;
      goto_cyc(18);
      n_cmp++; if (pcm_rdy[2] !== 1'b1) begin n_bad++; $display("FAIL coll_rdy_before: got %b want 1", pcm_rdy[2]); end
      pcm_in[23:16] = 8'h90;
      pcm_vld = 4'b0100;
      @(negedge clk);
      pcm_vld = 4'h0;
      n_cmp++; if (pcm_rdy[2] !== 1'b0) begin n_bad++; $display("FAIL coll_fresh: got rdy2=%b want 0", pcm_rdy[2]); end
      goto_cyc(20);
      n_cmp++; if (mix_vld !== 1'b1 || mix_out !== model_mix(s_old, 4'hF, 8'h00))
         begin n_bad++; $display("FAIL coll_old_mix: got vld=%b out=%h want %h", mix_vld, mix_out, model_mix(s_old, 4'hF, 8'h00)); end
      goto_cyc(36);
      n_cmp++; if (mix_vld !== 1'b1 || mix_out !== model_mix(s_new, 4'hF, 8'h00))
         begin n_bad++; $display("FAIL coll_new_mix: got vld=%b out=%h want %h", mix_vld, mix_out, model_mix(s_new, 4'hF, 8'h00)); end
      n_cmp++; if (pcm_rdy !== 4'hF) begin n_bad++; $display("FAIL coll_rdy_after: got %b want 1111", pcm_rdy); end
   endtask

   task automatic test_random();
      logic [7:0]  mh [NCH];
      logic [7:0]  snap [NCH];
      logic [31:0] sv;
      logic [7:0]  exp_mix;
      int          pos;
      do_reset();
      for (int i = 0; i < NCH; i++) mh[i] = 8'h80;
      for (int i = 0; i < NCH; i++) snap[i] = 8'h80;
      ch_en = 4'($urandom);
      gain  = 8'($urandom);
      while (cyc < 16 * 12 + 6) begin
         pos = cyc % DIV;
         if (cyc >= 16 && pos < NCH) snap[pos] = mh[pos];
         if (cyc >= 16 && pos == NCH) begin
            sv = {snap[3], snap[2], snap[1], snap[0]};
            exp_mix = model_mix(sv, ch_en, gain);
            n_cmp++; if (mix_vld !== 1'b1 || mix_out !== exp_mix)
               begin n_bad++; $display("FAIL rand_mix_cyc%0d: got vld=%b out=%h want %h", cyc, mix_vld, mix_out, exp_mix); end
         end
         if (pos == 8) begin
            ch_en = 4'($urandom);
            gain  = 8'($urandom);
         end
         pcm_in  = $urandom;
         pcm_vld = 4'($urandom);
         for (int i = 0; i < NCH; i++) begin
            if (pcm_vld[i] && pcm_rdy[i]) mh[i] = pcm_in[8*i +: 8];
         end
         @(negedge clk);
      end
      pcm_vld = 4'h0;
      n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL rand_overrun: got %b want 0", overrun); end
   endtask

   initial begin
      test_reset();
      test_all_c0();
      test_gain();
      test_negative();
      test_stall_overrun();
      test_capture_collision();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
